// File: rtl/usb_rx_pkg.sv
// Shared types and default constants for the USB receive packet sequencer.
package usb_rx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SYNC,
      ST_RX_BYTE,
      ST_EOP1,
      ST_EOP2,
      ST_DONE,
      ST_ERR_WAIT
   } rx_ctrl_state_t;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
   localparam int         STUFF_LEN_DEF = 6;
   localparam int         MAX_BYTES_DEF = 64;

endpackage

// File: rtl/rx_bit_shifter.sv
// LSB-first bit assembler with bit-stuff removal: tracks the run of 1s and
// flags the slot after STUFF_LEN ones as a stuff bit (must be 0).
module rx_bit_shifter #(
   parameter int STUFF_LEN = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       sample,
   input  logic       d_orig,
   output logic       bit_accept,
   output logic       byte_full,
   output logic       stuff_err,
   output logic [7:0] sr_next,
   output logic [2:0] bit_cnt
);

   localparam int OW = $clog2(STUFF_LEN + 1);

   logic [7:0]    sr_q, sr_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [OW-1:0] ones_q, ones_d;
   logic          stuff_slot;

   always_comb begin
      stuff_slot = (ones_q == OW'(STUFF_LEN));
      bit_accept = sample & ~stuff_slot;
      stuff_err  = sample & stuff_slot & d_orig;
      byte_full  = bit_accept & (bit_cnt_q == 3'd7);
      sr_next    = {d_orig, sr_q[7:1]};
      bit_cnt    = bit_cnt_q;

      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      ones_d    = ones_q;
      if (clr) begin
         sr_d      = '0;
         bit_cnt_d = '0;
         ones_d    = '0;
      end else if (sample) begin
         if (stuff_slot) begin
            // Stuffed 0 is dropped and restarts the run count.
            ones_d = '0;
         end else begin
            sr_d      = sr_next;
            bit_cnt_d = bit_cnt_q + 3'd1;
            ones_d    = d_orig ? ones_q + OW'(1) : '0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr_q      <= '0;
         bit_cnt_q <= '0;
         ones_q    <= '0;
      end else begin
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         ones_q    <= ones_d;
      end
   end

endmodule

// File: rtl/rx_packet_ctrl.sv
// Receive-side packet sequencer: SYNC check, byte assembly, EOP validation
// and error hold-off until the bus returns to idle.
module rx_packet_ctrl
   import usb_rx_pkg::*;
#(
   parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
   parameter int         STUFF_LEN = STUFF_LEN_DEF,
   parameter int         MAX_BYTES = MAX_BYTES_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       d_edge,
   input  logic       d_orig,
   input  logic       eop,
   input  logic       en_sample,
   output logic       timer_run,
   output logic       timer_clear,
   output logic       rcving,
   output logic [7:0] rx_data,
   output logic       byte_ready,
   output logic       pkt_done,
   output logic       r_error
);

   localparam int BW = $clog2(MAX_BYTES + 2);

   rx_ctrl_state_t state_q, state_d;
   logic [BW-1:0]  byte_cnt_q, byte_cnt_d;
   logic [7:0]     rx_data_q, rx_data_d;
   logic           timer_run_q, timer_run_d;
   logic           timer_clear_q, timer_clear_d;
   logic           rcving_q, rcving_d;
   logic           byte_ready_q, byte_ready_d;
   logic           pkt_done_q, pkt_done_d;
   logic           r_error_q, r_error_d;
   logic           seen_eop_q, seen_eop_d;

   logic       clr, sample;
   logic       bit_accept, byte_full, stuff_err;
   logic [7:0] sr_next;
   logic [2:0] bit_cnt;

   assign sample = en_sample & ~eop & ((state_q == ST_SYNC) | (state_q == ST_RX_BYTE));

   rx_bit_shifter #(.STUFF_LEN(STUFF_LEN)) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .clr        (clr),
      .sample     (sample),
      .d_orig     (d_orig),
      .bit_accept (bit_accept),
      .byte_full  (byte_full),
      .stuff_err  (stuff_err),
      .sr_next    (sr_next),
      .bit_cnt    (bit_cnt)
   );

   always_comb begin
      state_d       = state_q;
      byte_cnt_d    = byte_cnt_q;
      rx_data_d     = rx_data_q;
      r_error_d     = r_error_q;
      seen_eop_d    = 1'b0;
      byte_ready_d  = 1'b0;
      timer_clear_d = 1'b0;
      clr           = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (d_edge) begin
               state_d       = ST_SYNC;
               timer_clear_d = 1'b1;
               r_error_d     = 1'b0;
               byte_cnt_d    = '0;
               clr           = 1'b1;
            end
         end
         ST_SYNC, ST_RX_BYTE: begin
            if (en_sample) begin
               if (eop) begin
                  state_d = (state_q == ST_RX_BYTE && bit_cnt == 3'd0) ? ST_EOP1 : ST_ERR_WAIT;
               end else if (stuff_err) begin
                  state_d = ST_ERR_WAIT;
               end else if (byte_full) begin
                  if (state_q == ST_SYNC) begin
                     state_d = (sr_next == SYNC_BYTE) ? ST_RX_BYTE : ST_ERR_WAIT;
                  end else if (byte_cnt_q == BW'(MAX_BYTES)) begin
                     state_d = ST_ERR_WAIT;
                  end else begin
                     byte_cnt_d   = byte_cnt_q + BW'(1);
                     rx_data_d    = sr_next;
                     byte_ready_d = 1'b1;
                  end
               end
            end
         end
         ST_EOP1: begin
            if (en_sample) state_d = eop ? ST_EOP2 : ST_ERR_WAIT;
         end
         ST_EOP2: begin
            if (en_sample) state_d = eop ? ST_ERR_WAIT : ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR_WAIT: begin
            // Wait for SE0 then J so we resynchronise on a fresh packet.
            seen_eop_d = seen_eop_q | eop;
            if (seen_eop_q && !eop) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_ERR_WAIT) r_error_d = 1'b1;

      timer_run_d = (state_d == ST_SYNC) | (state_d == ST_RX_BYTE) |
                    (state_d == ST_EOP1) | (state_d == ST_EOP2);
      rcving_d    = timer_run_d;
      pkt_done_d  = (state_d == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         byte_cnt_q    <= '0;
         rx_data_q     <= '0;
         timer_run_q   <= 1'b0;
         timer_clear_q <= 1'b0;
         rcving_q      <= 1'b0;
         byte_ready_q  <= 1'b0;
         pkt_done_q    <= 1'b0;
         r_error_q     <= 1'b0;
         seen_eop_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         byte_cnt_q    <= byte_cnt_d;
         rx_data_q     <= rx_data_d;
         timer_run_q   <= timer_run_d;
         timer_clear_q <= timer_clear_d;
         rcving_q      <= rcving_d;
         byte_ready_q  <= byte_ready_d;
         pkt_done_q    <= pkt_done_d;
         r_error_q     <= r_error_d;
         seen_eop_q    <= seen_eop_d;
      end
   end

   assign timer_run   = timer_run_q;
   assign timer_clear = timer_clear_q;
   assign rcving      = rcving_q;
   assign rx_data     = rx_data_q;
   assign byte_ready  = byte_ready_q;
   assign pkt_done    = pkt_done_q;
   assign r_error     = r_error_q;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed bench for rx_packet_ctrl: default instance plus a MAX_BYTES=4
// instance driven by the same bus stimulus.
module tb_rx_packet_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic d_edge = 1'b0, d_orig = 1'b0, eop = 1'b0, en_sample = 1'b0;

   logic       a_timer_run, a_timer_clear, a_rcving, a_byte_ready, a_pkt_done, a_r_error;
   logic [7:0] a_rx_data;
   logic       b_timer_run, b_timer_clear, b_rcving, b_byte_ready, b_pkt_done, b_r_error;
   logic [7:0] b_rx_data;

   always #5 clk = ~clk;

   rx_packet_ctrl dut (
      .clk(clk), .rst(rst), .d_edge(d_edge), .d_orig(d_orig), .eop(eop), .en_sample(en_sample),
      .timer_run(a_timer_run), .timer_clear(a_timer_clear), .rcving(a_rcving), .rx_data(a_rx_data),
      .byte_ready(a_byte_ready), .pkt_done(a_pkt_done), .r_error(a_r_error)
   );

   rx_packet_ctrl #(.MAX_BYTES(4)) dut4 (
      .clk(clk), .rst(rst), .d_edge(d_edge), .d_orig(d_orig), .eop(eop), .en_sample(en_sample),
      .timer_run(b_timer_run), .timer_clear(b_timer_clear), .rcving(b_rcving), .rx_data(b_rx_data),
      .byte_ready(b_byte_ready), .pkt_done(b_pkt_done), .r_error(b_r_error)
   );

   int n_vec = 0;
   int n_miss = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Pulse monitors, sampled mid-cycle.
   int br_a = 0, pd_a = 0, tc_a = 0, br_b = 0, pd_b = 0, ovl = 0;
   logic [7:0] bytes_a[$];

   always @(negedge clk) begin
      if (a_byte_ready) begin
         br_a++;
         bytes_a.push_back(a_rx_data);
      end
      if (a_pkt_done)    pd_a++;
      if (a_timer_clear) tc_a++;
      if (b_byte_ready)  br_b++;
      if (b_pkt_done)    pd_b++;
      if (int'(a_byte_ready) + int'(a_pkt_done) + int'(a_timer_clear) > 1) ovl++;
   end

   task automatic send_bit(input logic b, input logic e);
      repeat (2) @(negedge clk);
      d_orig    = b;
      eop       = e;
      en_sample = 1'b1;
      @(posedge clk);
      #1;
      en_sample = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int i = 0; i < 8; i++) send_bit(v[i], 1'b0);
   endtask

   task automatic edge_pulse();
      @(negedge clk);
      d_edge = 1'b1;
      @(posedge clk);
      #1;
      d_edge = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int br0, pd0, tc0, q0, brb0, pdb0;

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_timer_run",   a_timer_run,   0);
      chk("rst_timer_clear", a_timer_clear, 0);
      chk("rst_rcving",      a_rcving,      0);
      chk("rst_rx_data",     a_rx_data,     0);
      chk("rst_byte_ready",  a_byte_ready,  0);
      chk("rst_pkt_done",    a_pkt_done,    0);
      chk("rst_r_error",     a_r_error,     0);

      // 1: reset pulse in the middle of SYNC
      br0 = br_a; pd0 = pd_a;
      edge_pulse();
      chk("t1_timer_clear", a_timer_clear, 1);
      chk("t1_timer_run",   a_timer_run,   1);
      chk("t1_rcving",      a_rcving,      1);
      for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("t1_rst_rcving",    a_rcving,    0);
      chk("t1_rst_timer_run", a_timer_run, 0);
      @(negedge clk);
      rst = 1'b0;
      idle(6);
      chk("t1_no_byte_ready", br_a - br0, 0);
      chk("t1_no_pkt_done",   pd_a - pd0, 0);

      // 2: clean two-byte packet
      br0 = br_a; pd0 = pd_a; tc0 = tc_a; q0 = bytes_a.size(); brb0 = br_b; pdb0 = pd_b;
      edge_pulse();
      send_byte(8'h80);
      send_byte(8'hC3);
      chk("t2_rx_data0", a_rx_data, 8'hC3);
      send_byte(8'hA5);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      chk("t2_pkt_done_now", a_pkt_done, 1);
      chk("t2_rcving_done",  a_rcving,   0);
      idle(4);
      chk("t2_pkt_done_gone", a_pkt_done, 0);
      chk("t2_timer_clears", tc_a - tc0, 1);
      chk("t2_byte_readys",  br_a - br0, 2);
      chk("t2_byte0", (bytes_a.size() > q0)     ? bytes_a[q0]     : 8'h00, 8'hC3);
      chk("t2_byte1", (bytes_a.size() > q0 + 1) ? bytes_a[q0 + 1] : 8'h00, 8'hA5);
      chk("t2_pkt_dones",    pd_a - pd0, 1);
      chk("t2_r_error",      a_r_error, 0);
      chk("t2_rx_data_held", a_rx_data, 8'hA5);
      chk("t2_b_byte_readys", br_b - brb0, 2);
      chk("t2_b_pkt_dones",   pd_b - pdb0, 1);

      // 3: bad SYNC (0x81), error held until SE0->J then next edge
      br0 = br_a;
      edge_pulse();
      send_byte(8'h81);
      chk("t3_r_error",    a_r_error,    1);
      chk("t3_byte_ready", a_byte_ready, 0);
      chk("t3_rcving",     a_rcving,     0);
      edge_pulse();
      chk("t3_edge_ignored", a_timer_clear, 0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      idle(4);
      chk("t3_r_error_held", a_r_error, 1);
      chk("t3_no_bytes",     br_a - br0, 0);
      edge_pulse();
      chk("t3_r_error_clr",   a_r_error,     0);
      chk("t3_timer_clear",   a_timer_clear, 1);

      // 4: 0xFF with a stuffed zero (already in SYNC from the edge above)
      send_byte(8'h80);
      send_byte(8'h3C);
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("t4_byte_ready", a_byte_ready, 1);
      chk("t4_rx_data_ff", a_rx_data,    8'hFF);
      chk("t4_r_error",    a_r_error,    0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      chk("t4_pkt_done", a_pkt_done, 1);
      idle(3);
      edge_pulse();
      send_byte(8'h80);
      send_byte(8'h3C);
      for (int i = 0; i < 6; i++) send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      chk("t4_stuff_err",  a_r_error, 1);
      chk("t4_stuff_rcv",  a_rcving,  0);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      idle(3);

      // 5: SE0 mid-byte, then SE0 at the J slot
      pd0 = pd_a;
      edge_pulse();
      send_byte(8'h80);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      chk("t5_mid_err",    a_r_error, 1);
      chk("t5_mid_rcving", a_rcving,  0);
      send_bit(1'b1, 1'b0);
      idle(3);
      edge_pulse();
      send_byte(8'h80);
      send_byte(8'h3C);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      chk("t5_eop2_rcving", a_rcving, 1);
      send_bit(1'b0, 1'b1);
      chk("t5_eop2_err",   a_r_error, 1);
      chk("t5_no_pkt_done", pd_a - pd0, 0);
      send_bit(1'b1, 1'b0);
      idle(3);

      // 6: five data bytes; the MAX_BYTES=4 instance must reject the 5th
      br0 = br_a; pd0 = pd_a; brb0 = br_b; pdb0 = pd_b;
      edge_pulse();
      send_byte(8'h80);
      send_byte(8'hC3);
      send_byte(8'hA5);
      send_byte(8'h3C);
      send_byte(8'h5A);
      chk("t6_b_r_error_before", b_r_error, 0);
      send_byte(8'h0F);
      chk("t6_b_r_error",    b_r_error,    1);
      chk("t6_b_byte_ready", b_byte_ready, 0);
      chk("t6_a_byte_ready", a_byte_ready, 1);
      chk("t6_a_rx_data",    a_rx_data,    8'h0F);
      send_bit(1'b0, 1'b1);
      send_bit(1'b0, 1'b1);
      send_bit(1'b1, 1'b0);
      chk("t6_a_pkt_done", a_pkt_done, 1);
      idle(4);
      chk("t6_b_byte_readys", br_b - brb0, 4);
      chk("t6_b_pkt_dones",   pd_b - pdb0, 0);
      chk("t6_b_rx_data",     b_rx_data,   8'h5A);
      chk("t6_a_byte_readys", br_a - br0,  5);
      chk("t6_a_pkt_dones",   pd_a - pd0,  1);
      chk("t6_b_rcving",      b_rcving,    0);

      chk("pulse_overlap", ovl, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
